// File: rtl/gcm_tag_verify.sv
// Decrypt-side GCM tag check: GHASH over AAD/ciphertext blocks plus the length
// block, then S = GHASH ^ E(K,J0) compared against the received tag.
module gcm_tag_verify #(
    parameter int DATA__WIDTH = 128,
    parameter int SPLIT_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [DATA__WIDTH-1:0] h_i,
    input  logic [DATA__WIDTH-1:0] ekj0_i,
    input  logic [DATA__WIDTH-1:0] tag_i,
    input  logic [63:0]            len_a_i,
    input  logic [63:0]            len_c_i,
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [DATA__WIDTH-1:0] blk_data_i,
    input  logic [4:0]             blk_bytes_i,
    input  logic                   blk_last_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   tag_ok_o,
    output logic [DATA__WIDTH-1:0] s_o,
    output logic [2:0]             dbg_state_o
);
    localparam int NCYC = DATA__WIDTH / SPLIT_WIDTH;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [DATA__WIDTH-1:0] R = {8'he1, {(DATA__WIDTH-8){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACCEPT, MUL, LENMUL, FINAL} state_t;

    // Handshake: a block transfers on a rising edge where blk_valid_i and
    // blk_ready_o are both high; blk_ready_o is high only in ACCEPT.
    state_t                 state_q;
    logic [DATA__WIDTH-1:0] h_q, ekj0_q, tag_q, len_q;
    logic [DATA__WIDTH-1:0] y_q, z_q, v_q;
    logic [CW-1:0]          cnt_q;
    logic                   last_q;

    logic [4:0]             nbytes;
    logic [DATA__WIDTH-1:0] mask, masked;
    logic [DATA__WIDTH-1:0] h_sh;
    logic [SPLIT_WIDTH-1:0] chunk;
    logic [DATA__WIDTH-1:0] z_nx, v_nx;
    logic                   cnt_last;

    assign blk_ready_o = (state_q == ACCEPT);
    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;
    assign cnt_last    = (cnt_q == CW'(NCYC - 1));

    always_comb begin
        nbytes = blk_bytes_i;
        if (blk_bytes_i == 5'd0 || blk_bytes_i > 5'd16)
            nbytes = 5'd16;
        mask = '0;
        for (int b = 0; b < 16; b++)
            mask[DATA__WIDTH-1-8*b -: 8] = (5'(b) < nbytes) ? 8'hff : 8'h00;
        masked = blk_data_i & mask;
    end

    // One slice of the bit-serial multiply: SPLIT_WIDTH bits of H, MSB first.
    always_comb begin
        h_sh  = h_q << (SPLIT_WIDTH * int'(cnt_q));
        chunk = h_sh[DATA__WIDTH-1 -: SPLIT_WIDTH];
        z_nx  = z_q;
        v_nx  = v_q;
        for (int i = 0; i < SPLIT_WIDTH; i++) begin
            if (chunk[SPLIT_WIDTH-1-i])
                z_nx = z_nx ^ v_nx;
            v_nx = v_nx[0] ? ((v_nx >> 1) ^ R) : (v_nx >> 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            h_q      <= '0;
            ekj0_q   <= '0;
            tag_q    <= '0;
            len_q    <= '0;
            y_q      <= '0;
            z_q      <= '0;
            v_q      <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            done_o   <= 1'b0;
            tag_ok_o <= 1'b0;
            s_o      <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        h_q      <= h_i;
                        ekj0_q   <= ekj0_i;
                        tag_q    <= tag_i;
                        len_q    <= {len_a_i, len_c_i};
                        y_q      <= '0;
                        z_q      <= '0;
                        v_q      <= {len_a_i, len_c_i};
                        cnt_q    <= '0;
                        tag_ok_o <= 1'b0;
                        s_o      <= '0;
                        state_q  <= (len_a_i == 64'd0 && len_c_i == 64'd0) ? LENMUL : ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (blk_valid_i) begin
                        v_q     <= y_q ^ masked;
                        z_q     <= '0;
                        cnt_q   <= '0;
                        last_q  <= blk_last_i;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    if (cnt_last) begin
                        y_q   <= z_nx;
                        z_q   <= '0;
                        cnt_q <= '0;
                        // Preload the length block so LENMUL starts without a gap.
                        if (last_q) begin
                            v_q     <= z_nx ^ len_q;
                            state_q <= LENMUL;
                        end else begin
                            state_q <= ACCEPT;
                        end
                    end else begin
                        z_q   <= z_nx;
                        v_q   <= v_nx;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LENMUL: begin
                    if (cnt_last) begin
                        y_q     <= z_nx;
                        cnt_q   <= '0;
                        state_q <= FINAL;
                    end else begin
                        z_q   <= z_nx;
                        v_q   <= v_nx;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FINAL: begin
                    s_o      <= y_q ^ ekj0_q;
                    tag_ok_o <= ((y_q ^ ekj0_q) == tag_q);
                    done_o   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcm_tag_verify.sv
// Bench for gcm_tag_verify: polynomial-arithmetic GHASH model, a cycle-exact
// expected-result queue, directed GCM vectors and randomized messages.
module tb_gcm_tag_verify;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [127:0] h_i, ekj0_i, tag_i;
    logic [63:0]  len_a_i, len_c_i;
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic [127:0] blk_data_i;
    logic [4:0]   blk_bytes_i;
    logic         blk_last_i;
    logic         busy_o, done_o, tag_ok_o;
    logic [127:0] s_o;
    logic [2:0]   dbg_state_o;

    localparam logic [127:0] H0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] E0  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] C0  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] T1  = 128'hab6e47d42cec13bdf53a67b21257bddf;

    gcm_tag_verify dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .h_i(h_i), .ekj0_i(ekj0_i),
        .tag_i(tag_i), .len_a_i(len_a_i), .len_c_i(len_c_i), .blk_valid_i(blk_valid_i),
        .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i), .blk_bytes_i(blk_bytes_i),
        .blk_last_i(blk_last_i), .busy_o(busy_o), .done_o(done_o), .tag_ok_o(tag_ok_o),
        .s_o(s_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk_i = ~clk_i;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [127:0] rev128(input logic [127:0] a);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = a[127-i];
        return r;
    endfunction

    // GCM bit order is reflected: map to coefficient order, carry-less
    // multiply, reduce by x^128 + x^7 + x^2 + x + 1, map back.
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] h);
        logic [255:0] p, a, poly;
        logic [127:0] b;
        a = {128'b0, rev128(x)};
        b = rev128(h);
        p = '0;
        for (int i = 0; i < 128; i++)
            if (b[i]) p = p ^ (a << i);
        poly = '0;
        poly[128] = 1'b1; poly[7] = 1'b1; poly[2] = 1'b1; poly[1] = 1'b1; poly[0] = 1'b1;
        for (int i = 254; i >= 128; i--)
            if (p[i]) p = p ^ (poly << (i - 128));
        return rev128(p[127:0]);
    endfunction

    function automatic logic [127:0] mask_blk(input logic [127:0] d, input int nb);
        int n;
        logic [127:0] keep;
        n = (nb == 0 || nb > 16) ? 16 : nb;
        keep = {128{1'b1}};
        keep = keep << (8 * (16 - n));
        return d & keep;
    endfunction

    logic [127:0] m_blk[$];
    int           m_nb[$];

    function automatic logic [127:0] model_s(input logic [127:0] h, input logic [127:0] e,
                                             input logic [63:0] la, input logic [63:0] lc);
        logic [127:0] y;
        y = '0;
        foreach (m_blk[i]) y = gf_mul(y ^ mask_blk(m_blk[i], m_nb[i]), h);
        y = gf_mul(y ^ {la, lc}, h);
        return y ^ e;
    endfunction

    // ---------------- scoreboard ----------------
    int           exp_cyc_q[$];
    logic [127:0] exp_q[$];
    logic         exp_ok_q[$];

    always @(negedge clk_i) begin : compare
        logic due;
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            void'(exp_cyc_q.pop_front());
            void'(exp_q.pop_front());
            void'(exp_ok_q.pop_front());
        end
        due = (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc);
        chk("done_pulse", done_o, due);
        if (due) begin
            chk("s_out", s_o, exp_q[0]);
            chk("tag_ok", tag_ok_o, exp_ok_q[0]);
            void'(exp_cyc_q.pop_front());
            void'(exp_q.pop_front());
            void'(exp_ok_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_start(input logic [127:0] h, input logic [127:0] e, input logic [127:0] t,
                            input logic [63:0] la, input logic [63:0] lc, output int edge_c);
        h_i = h; ekj0_i = e; tag_i = t; len_a_i = la; len_c_i = lc;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        edge_c  = cyc;
        start_i = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] d, input int nb, input logic last,
                            input logic inject, output int hs);
        logic got;
        got = 1'b0;
        hs = cyc;
        blk_valid_i = 1'b1; blk_data_i = d; blk_bytes_i = 5'(nb); blk_last_i = last;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (inject && k == 1) begin
                h_i = rnd128(); tag_i = rnd128(); len_a_i = 64'd0; len_c_i = 64'd0;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            if (blk_ready_o) begin
                @(posedge clk_i); #1;
                hs = cyc;
                got = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
        if (!got) chk("handshake_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_msg(input logic [127:0] h, input logic [127:0] e, input logic [63:0] la,
                           input logic [63:0] lc, input logic flip, input logic inject);
        logic [127:0] s, t;
        int st, hs, prev, n;
        s = model_s(h, e, la, lc);
        t = flip ? (s ^ 128'h1) : s;
        do_start(h, e, t, la, lc, st);
        n = m_blk.size();
        hs = st;
        prev = st;
        for (int i = 0; i < n; i++) begin
            send_blk(m_blk[i], m_nb[i], (i == n - 1), inject && (i == 1), hs);
            chk("blk_gap", 128'(hs - prev), (i == 0) ? 128'd1 : 128'd5);
            prev = hs;
        end
        blk_valid_i = 1'b0;
        exp_cyc_q.push_back((n == 0) ? st + 5 : hs + 9);
        exp_q.push_back(s);
        exp_ok_q.push_back(!flip);
        for (int k = 0; k < 40 && exp_cyc_q.size() > 0; k++) begin
            @(negedge clk_i);
            chk("ready_quiet", blk_ready_o, 1'b0);
        end
        if (exp_cyc_q.size() > 0) begin
            chk("done_timeout", 1'b0, 1'b1);
            exp_cyc_q.delete(); exp_q.delete(); exp_ok_q.delete();
        end
        @(posedge clk_i); #1;
    endtask

    task automatic chk_idle_zero(input string nm);
        @(negedge clk_i);
        chk({nm, "_done"}, done_o, 1'b0);
        chk({nm, "_busy"}, busy_o, 1'b0);
        chk({nm, "_ready"}, blk_ready_o, 1'b0);
        chk({nm, "_tag_ok"}, tag_ok_o, 1'b0);
        chk({nm, "_s"}, s_o, 128'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int hs, st, nblk, naad, nbl, sel;
        logic [127:0] d;
        rst_i = 1'b1; start_i = 1'b0; h_i = '0; ekj0_i = '0; tag_i = '0;
        len_a_i = '0; len_c_i = '0; blk_valid_i = 1'b0; blk_data_i = '0;
        blk_bytes_i = '0; blk_last_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk_idle_zero("reset");

        // Pin the model to published GCM vectors.
        m_blk.delete(); m_nb.delete();
        chk("model_empty", model_s(H0, E0, 64'd0, 64'd0), E0);
        m_blk.push_back(C0); m_nb.push_back(16);
        chk("model_one_blk", model_s(H0, E0, 64'd0, 64'd128), T1);

        // Blocks offered while idle must be ignored.
        blk_valid_i = 1'b1; blk_data_i = C0; blk_bytes_i = 5'd16;
        repeat (3) begin
            @(negedge clk_i);
            chk("idle_ready", blk_ready_o, 1'b0);
        end
        @(posedge clk_i); #1 blk_valid_i = 1'b0;

        m_blk.delete(); m_nb.delete();
        run_msg(H0, E0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("empty_s", s_o, E0);
        chk("empty_ok", tag_ok_o, 1'b1);

        m_blk.push_back(C0); m_nb.push_back(16);
        run_msg(H0, E0, 64'd0, 64'd128, 1'b0, 1'b0);
        chk("one_blk_s", s_o, T1);
        chk("one_blk_ok", tag_ok_o, 1'b1);

        run_msg(H0, E0, 64'd0, 64'd128, 1'b1, 1'b0);
        chk("bad_tag_s", s_o, T1);
        chk("bad_tag_ok", tag_ok_o, 1'b0);

        m_blk.delete(); m_nb.delete();
        m_blk.push_back({C0[127:64], $urandom | 32'h1, $urandom}); m_nb.push_back(8);
        run_msg(H0, E0, 64'd0, 64'd64, 1'b0, 1'b0);
        chk("partial_ok", tag_ok_o, 1'b1);

        // Back-to-back blocks with a stray start during the multiply.
        m_blk.delete(); m_nb.delete();
        m_blk.push_back(rnd128()); m_nb.push_back(16);
        m_blk.push_back(rnd128()); m_nb.push_back(16);
        run_msg(H0, E0, 64'd128, 64'd128, 1'b0, 1'b1);
        chk("bp_ok", tag_ok_o, 1'b1);

        // Reset while the length block is being multiplied.
        m_blk.delete(); m_nb.delete();
        do_start(H0, E0, T1, 64'd0, 64'd128, st);
        send_blk(C0, 16, 1'b1, 1'b0, hs);
        blk_valid_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        chk("pre_rst_busy", busy_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        chk_idle_zero("mid_rst");
        repeat (12) @(posedge clk_i);
        #1;
        run_msg(H0, E0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("post_rst_ok", tag_ok_o, 1'b1);

        // Randomized messages.
        for (int r = 0; r < 12; r++) begin
            m_blk.delete(); m_nb.delete();
            nblk = $urandom_range(1, 4);
            naad = $urandom_range(0, nblk - 1);
            nbl  = $urandom_range(1, 16);
            for (int b = 0; b < nblk; b++) begin
                d = rnd128();
                m_blk.push_back(d);
                if (b == nblk - 1) begin
                    m_nb.push_back(nbl);
                end else begin
                    sel = $urandom_range(0, 3);
                    m_nb.push_back((sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(17, 31)) : 16);
                end
            end
            run_msg(rnd128(), rnd128(), 64'(128 * naad),
                    64'(128 * (nblk - naad - 1) + 8 * nbl),
                    ($urandom_range(0, 3) == 0), (nblk >= 2) && ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running want finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/gcm_tag_verify.md
Name: gcm_tag_verify

Overview:
- Decrypt-side GCM authentication block.
- Absorbs a stream of 128-bit AAD and ciphertext blocks and runs GHASH (Y = (Y ^ X) * H) on each one.
- Appends the len(A)||len(C) block, forms S = GHASH ^ E(K,J0), and compares S with the received tag.
- Complements the tag-generating GHASH path. Uses an iterative GF(2^128) multiplier that consumes 32 bits of H per cycle (4 cycles per block), with the same bit ordering and reduction polynomial as the encrypt path.

Parameters:
- DATA__WIDTH, 128, block and field width; only 128 is supported.
- SPLIT_WIDTH, 32, H bits processed per multiply cycle; must divide DATA__WIDTH (cycles per multiply = DATA__WIDTH/SPLIT_WIDTH).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse; captures h_i, ekj0_i, tag_i, len_a_i, len_c_i.
- h_i  in  128  hash subkey H.
- ekj0_i  in  128  E(K,J0).
- tag_i  in  128  received tag.
- len_a_i  in  64  AAD length in bits.
- len_c_i  in  64  ciphertext length in bits.
- blk_valid_i  in  1  block offered.
- blk_ready_o  out  1  block accepted when valid & ready.
- blk_data_i  in  128  block, byte 0 in [127:120].
- blk_bytes_i  in  5  valid bytes, 1..16; trailing bytes are forced to zero internally.
- blk_last_i  in  1  final data block.
- busy_o  out  1  high from start accept until done.
- done_o  out  1  one-cycle pulse when the result is valid.
- tag_ok_o  out  1  1 = tag match; held until the next start.
- s_o  out  128  computed S; held until the next start.

Behaviour:
- Reset values: all outputs 0; state IDLE; Y=0.
- Reduction constant R = 128'he1000000000000000000000000000000.
- Multiply algorithm, per operand X:
  - Load V = Y ^ X, Z = 0.
  - For k = 0..127 in order: if H[127-k], Z ^= V; then V = V[0] ? (V>>1)^R : V>>1.
  - SPLIT_WIDTH iterations run per cycle. Cycle c uses H[127-32c -: 32].
  - After the last cycle, Y <= Z.
- State IDLE:
  - busy_o=0, blk_ready_o=0.
  - On start_i: latch all inputs, Y<=0, tag_ok_o<=0, s_o<=0.
  - If len_a_i==0 and len_c_i==0, go to LENMUL; otherwise go to ACCEPT.
- State ACCEPT:
  - blk_ready_o=1.
  - On a handshake: mask bytes >= blk_bytes_i to zero; blk_bytes_i of 0 or greater than 16 is treated as 16.
  - Latch blk_last_i, then go to MUL.
- State MUL:
  - Runs 4 cycles with blk_ready_o=0.
  - Then goes to LENMUL if the latched last flag is set, else back to ACCEPT.
  - Block-to-block throughput is 5 cycles.
- State LENMUL:
  - 4-cycle multiply with X = {len_a, len_c}, then go to FINAL.
- State FINAL (1 cycle):
  - s_o <= Y ^ ekj0, tag_ok_o <= (Y ^ ekj0) == tag, done_o=1.
  - Return to IDLE.
- Latency: from the last-block handshake to done_o is 4 (MUL) + 4 (LENMUL) + 1 = 9 cycles.
- start_i while busy_o=1 is ignored.
- blk_valid_i in IDLE is ignored, with no ready asserted.
- The module does not check block count against the lengths; the caller owns framing. The AAD/ciphertext boundary needs no marker because both are padded per block.
- rst_i mid-operation: returns to IDLE next edge; outputs zeroed; no done pulse.
- Holding blk_valid_i with data changing while ready is low has no effect; only the handshake cycle samples.

Test Plan:
- Empty message:
  - Stimulus: H=66e94bd4ef8a2c3b884cfa59ca342b2e, ekj0=58e2fccefa7e3061367f1d57a4e7455a, tag=ekj0, both lengths 0.
  - Response: no blk_ready_o; done_o 5 cycles after start; s_o=58e2fccefa7e3061367f1d57a4e7455a; tag_ok_o=1.
- One ciphertext block:
  - Stimulus: same H and ekj0, len_c=128, block 0388dace60b6a392f328c2b971b2fe78 with last=1, tag=ab6e47d42cec13bdf53a67b21257bddf.
  - Response: tag_ok_o=1; done_o 9 cycles after the handshake.
- Corrupted tag:
  - Stimulus: as the previous test but tag bit 0 flipped.
  - Response: done_o pulses, tag_ok_o=0, s_o=ab6e47d42cec13bdf53a67b21257bddf.
- Partial block:
  - Stimulus: same setup, len_c=64, block with bytes 8..15 nonzero garbage, blk_bytes_i=8, tag computed by the reference model with those bytes zeroed.
  - Response: tag_ok_o=1, proving the masking.
- Backpressure and illegal inputs:
  - Stimulus: two blocks offered back-to-back with blk_valid_i held high.
  - Response: ready high only 1 cycle in every 5; start_i pulsed during MUL has no effect; reference-model tag matches.
- Reset mid-operation:
  - Stimulus: assert rst_i during LENMUL, then run the empty-message case.
  - Response: outputs 0 the cycle after reset; the following empty-message run passes; no spurious done_o.
